// File: rtl/ahb_slave_xfer_ctrl_if.sv
// Bus bundle for ahb_slave_xfer_ctrl: AHB-Lite slave signals plus the TX drain and RX source streams.
// Stream handshake: a beat moves on a rising edge where valid and ready are both 1; valid never waits on ready.
interface ahb_slave_xfer_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY, HWDATA,
        input  tx_ready, rx_data, rx_valid,
        output HRDATA, HREADYOUT, HRESP, tx_data, tx_valid, rx_ready
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY, HWDATA,
        output tx_ready, rx_data, rx_valid,
        input  HRDATA, HREADYOUT, HRESP, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/ahb_slave_xfer_ctrl.sv
// AHB-Lite single-word slave: writes buffered into a TX FIFO, reads served from an RX stream with timeout.
// Optional status register at BASE_ADDR+4 enabled by defining AHB_SLV_STATUS_EN.
module ahb_slave_xfer_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'hF0F0F0F0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          RD_TIMEOUT = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_slave_xfer_ctrl_if.slave bus,
    output logic [2:0]           dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_DONE = 3'd3,
        ST_ERR1    = 3'd4,
        ST_ERR2    = 3'd5
    } state_t;

    state_t        state;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tcnt;
    logic [31:0]   hrdata_q;
    logic          hreadyout, hresp;
    logic          push, pop, wr_ok, accept, ctrl_ok, base_hit, legal_wr, legal_rd;

    assign pop   = (count != '0) && bus.tx_ready;
    assign wr_ok = (count < CW'(FIFO_DEPTH)) || pop;
    assign push  = (state == ST_WR) && wr_ok;

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            ST_WR:      hreadyout = wr_ok;
            ST_RD_WAIT: hreadyout = 1'b0;
            ST_ERR1:    begin hreadyout = 1'b0; hresp = 1'b1; end
            ST_ERR2:    hresp = 1'b1;
            default:    ;
        endcase
    end

    assign accept   = bus.HSEL && bus.HREADY && bus.HTRANS[1] && hreadyout;
    assign ctrl_ok  = (bus.HTRANS == 2'b10) && (bus.HBURST == 3'b000) && (bus.HSIZE == 3'b010);
    assign base_hit = (bus.HADDR == BASE_ADDR);
    assign legal_wr = ctrl_ok && bus.HWRITE && base_hit;

`ifdef AHB_SLV_STATUS_EN
    logic        stat_rd;
    logic        stat_hit;
    logic [31:0] status_word;
    assign stat_hit    = !bus.HWRITE && (bus.HADDR == BASE_ADDR + 32'd4);
    assign status_word = {23'b0, bus.rx_valid, 8'(count)};
    assign legal_rd    = ctrl_ok && !bus.HWRITE && (base_hit || stat_hit);
    assign bus.rx_ready = (state == ST_RD_WAIT) && bus.rx_valid && !stat_rd;
`else
    assign legal_rd     = ctrl_ok && !bus.HWRITE && base_hit;
    assign bus.rx_ready = (state == ST_RD_WAIT) && bus.rx_valid;
`endif

    // Address decisions are only taken in cycles that complete the previous data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            tcnt     <= '0;
            hrdata_q <= '0;
`ifdef AHB_SLV_STATUS_EN
            stat_rd  <= 1'b0;
`endif
        end else if (hreadyout) begin
            if (accept && legal_wr) begin
                state <= ST_WR;
            end else if (accept && legal_rd) begin
                state <= ST_RD_WAIT;
                tcnt  <= '0;
`ifdef AHB_SLV_STATUS_EN
                stat_rd <= stat_hit;
`endif
            end else if (accept) begin
                state <= ST_ERR1;
            end else begin
                state <= ST_IDLE;
            end
        end else begin
            case (state)
                ST_RD_WAIT: begin
`ifdef AHB_SLV_STATUS_EN
                    if (stat_rd) begin
                        hrdata_q <= status_word;
                        state    <= ST_RD_DONE;
                    end else
`endif
                    if (bus.rx_valid) begin
                        hrdata_q <= bus.rx_data;
                        state    <= ST_RD_DONE;
                    end else if (tcnt == TW'(RD_TIMEOUT - 1)) begin
                        tcnt  <= '0;
                        state <= ST_ERR1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem[wptr] <= bus.HWDATA;
    end

    assign bus.tx_data   = mem[rptr];
    assign bus.tx_valid  = (count != '0);
    assign bus.HRDATA    = hrdata_q;
    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign dbg_state     = state;
endmodule

// File: tb/tb_ahb_slave_xfer_ctrl.sv
// Self-checking bench for ahb_slave_xfer_ctrl: pipelined AHB driver, TX/RX stream control, scoreboards.
module tb_ahb_slave_xfer_ctrl;
    localparam logic [31:0] BASE = 32'hF0F0F0F0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
        bit          exp_err;
        int          exp_waits;
        logic [31:0] exp_rdata;
    } xfer_t;

    logic HCLK;
    logic HRESET;
    logic [2:0] dbg_state;
    ahb_slave_xfer_ctrl_if bus();

    ahb_slave_xfer_ctrl dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    assign bus.HREADY = bus.HREADYOUT;

    // clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_q[$];
    xfer_t       xq[$];
    int          rx_ready_cnt = 0;
    logic        tx_ready_dflt = 1'b0;
    int          stall_pulse_at = -1;
    int          rx_delay = -1;
    logic [31:0] rx_word = '0;
    logic [31:0] last_rd = '0;
    int          rx_before;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input xfer_t x);
        bit ok;
        bit hit;
        ok  = (x.trans == 2'b10) && (x.size == 3'b010) && (x.burst == 3'b000);
        hit = (x.addr == BASE);
`ifdef AHB_SLV_STATUS_EN
        hit = hit || (!x.wr && (x.addr == BASE + 32'd4));
`endif
        return ok && hit;
    endfunction

    task automatic add(input logic [31:0] addr, input logic wr, input logic [1:0] trans,
                       input logic [2:0] size, input logic [2:0] burst, input logic [31:0] wdata,
                       input bit force_err, input int exp_waits, input logic [31:0] exp_rdata);
        xfer_t x;
        x.addr = addr; x.wr = wr; x.trans = trans; x.size = size; x.burst = burst;
        x.wdata = wdata; x.exp_waits = exp_waits; x.exp_rdata = exp_rdata;
        x.exp_err = !legal(x) || force_err;
        xq.push_back(x);
    endtask

    task automatic bus_idle();
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'b010; bus.HBURST = 3'b000;
        bus.tx_ready = tx_ready_dflt; bus.rx_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK); #1;
        end
    endtask

    task automatic finish_xfer(input xfer_t dx, input int waits, input logic prev_resp);
        chk("resp", {31'b0, bus.HRESP}, {31'b0, dx.exp_err});
        if (dx.exp_waits >= 0) chk("waits", waits, dx.exp_waits);
        if (dx.exp_err) begin
            chk("err1_resp", {31'b0, prev_resp}, 32'd1);
        end else if (!dx.wr) begin
            if (rd_q.size() == 0) chk("rd_q_empty", 32'd1, 32'd0);
            else begin
                last_rd = rd_q.pop_front();
                chk("rdata", bus.HRDATA, last_rd);
            end
        end
    endtask

    // driver: pipelined address/data phases over xq; entered and left at posedge+1
    task automatic run_xfers();
        int    a, d, waits, guard;
        logic  prev_resp;
        xfer_t cx, dx;
        a = 0; d = -1; waits = 0; guard = 0; prev_resp = 1'b0;
        while ((a < xq.size() || d >= 0) && guard < 300) begin
            if (a < xq.size()) begin
                cx = xq[a];
                bus.HSEL = 1'b1; bus.HADDR = cx.addr; bus.HTRANS = cx.trans;
                bus.HWRITE = cx.wr; bus.HSIZE = cx.size; bus.HBURST = cx.burst;
            end else begin
                bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
            end
            bus.tx_ready = tx_ready_dflt;
            bus.rx_valid = 1'b0;
            if (d >= 0) begin
                dx = xq[d];
                bus.HWDATA = dx.wdata;
                if (dx.wr && waits == stall_pulse_at) bus.tx_ready = 1'b1;
                if (!dx.wr && waits == rx_delay) begin
                    bus.rx_valid = 1'b1;
                    bus.rx_data  = rx_word;
                end
            end
            @(negedge HCLK);
            if (bus.HREADYOUT) begin
                if (d >= 0) finish_xfer(dx, waits, prev_resp);
                if (a < xq.size()) begin
                    if (!xq[a].exp_err) begin
                        if (xq[a].wr) exp_q.push_back(xq[a].wdata);
                        else          rd_q.push_back(xq[a].exp_rdata);
                    end
                    d = a;
                    a++;
                end else begin
                    d = -1;
                end
                waits = 0;
            end else begin
                waits++;
            end
            prev_resp = bus.HRESP;
            @(posedge HCLK); #1;
            guard++;
        end
        if (guard >= 300) chk("run_timeout", 32'd1, 32'd0);
        bus_idle();
        xq.delete();
    endtask

    // scoreboard: TX pops and RX consumption
    always @(negedge HCLK) begin
        if (!HRESET && bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) chk("tx_extra", bus.tx_data, 32'hxxxxxxxx);
            else chk("tx_data", bus.tx_data, exp_q.pop_front());
        end
        if (!HRESET && bus.rx_ready) rx_ready_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1;
        bus.HWDATA = '0; bus.rx_data = '0;
        bus_idle();
        cycles(3);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
        chk("rst_hresp", {31'b0, bus.HRESP}, 32'd0);
        chk("rst_hrdata", bus.HRDATA, 32'd0);
        chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
        chk("rst_state", {29'b0, dbg_state}, 32'd0);
        @(posedge HCLK); #1;

        // single zero-wait write drained immediately
        tx_ready_dflt = 1'b1;
        add(BASE, 1'b1, 2'b10, 3'b010, 3'b000, 32'hDEADBEEF, 1'b0, 0, '0);
        run_xfers();
        cycles(2);
        chk("t1_drained", exp_q.size(), 32'd0);

        // five back-to-back writes into a stalled sink
        tx_ready_dflt = 1'b0;
        stall_pulse_at = 3;
        for (int i = 0; i < 5; i++)
            add(BASE, 1'b1, 2'b10, 3'b010, 3'b000, 32'hA0 + i, 1'b0, (i == 4) ? 3 : 0, '0);
        run_xfers();
        stall_pulse_at = -1;
        @(negedge HCLK);
        chk("t2_tx_valid_full", {31'b0, bus.tx_valid}, 32'd1);
        chk("t2_pending", exp_q.size(), 32'd4);
        @(posedge HCLK); #1;
        tx_ready_dflt = 1'b1; bus.tx_ready = 1'b1;
        cycles(6);
        chk("t2_drained", exp_q.size(), 32'd0);
        @(negedge HCLK);
        chk("t2_tx_valid_empty", {31'b0, bus.tx_valid}, 32'd0);
        @(posedge HCLK); #1;

        // read with rx_valid arriving after 3 wait cycles
        rx_before = rx_ready_cnt;
        rx_delay = 3; rx_word = 32'h12345678;
        add(BASE, 1'b0, 2'b10, 3'b010, 3'b000, '0, 1'b0, 4, 32'h12345678);
        run_xfers();
        chk("t3_rx_pulses", rx_ready_cnt - rx_before, 32'd1);

        // read timeout: 16 waits then the ERR1 cycle
        rx_before = rx_ready_cnt;
        rx_delay = -1;
        add(BASE, 1'b0, 2'b10, 3'b010, 3'b000, '0, 1'b1, 17, '0);
        run_xfers();
        chk("t4_rx_pulses", rx_ready_cnt - rx_before, 32'd0);

        // illegal transfers pipelined behind one good write; FIFO must keep only the good word
        tx_ready_dflt = 1'b0; bus.tx_ready = 1'b0;
        add(BASE,         1'b1, 2'b10, 3'b010, 3'b000, 32'h11,  1'b0, 0, '0);
        add(BASE,         1'b1, 2'b10, 3'b010, 3'b011, 32'hBAD1, 1'b0, 1, '0);
        add(BASE,         1'b0, 2'b10, 3'b000, 3'b000, '0,       1'b0, 1, '0);
        add(BASE + 32'd8, 1'b1, 2'b10, 3'b010, 3'b000, 32'hBAD2, 1'b0, 1, '0);
        add(BASE + 32'd4, 1'b1, 2'b10, 3'b010, 3'b000, 32'hBAD3, 1'b0, 1, '0);
        add(BASE,         1'b1, 2'b11, 3'b010, 3'b000, 32'hBAD4, 1'b0, 1, '0);
        add(BASE + 32'd4, 1'b0, 2'b10, 3'b010, 3'b000, '0,       1'b0, 1, 32'h00000001);
        run_xfers();
        @(negedge HCLK);
        chk("t5_pending", exp_q.size(), 32'd1);
        @(posedge HCLK); #1;
        tx_ready_dflt = 1'b1; bus.tx_ready = 1'b1;
        cycles(4);
        chk("t5_drained", exp_q.size(), 32'd0);
        @(negedge HCLK);
        chk("t5_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        chk("hrdata_hold", bus.HRDATA, last_rd);
        @(posedge HCLK); #1;

        // back-to-back write/read/write
        rx_delay = 0; rx_word = 32'hCAFEF00D;
        add(BASE, 1'b1, 2'b10, 3'b010, 3'b000, 32'h55, 1'b0, 0, '0);
        add(BASE, 1'b0, 2'b10, 3'b010, 3'b000, '0,     1'b0, 1, 32'hCAFEF00D);
        add(BASE, 1'b1, 2'b10, 3'b010, 3'b000, 32'h66, 1'b0, 0, '0);
        run_xfers();
        rx_delay = -1;
        cycles(3);
        chk("t6_drained", exp_q.size(), 32'd0);

        // BUSY and deselected NONSEQ are ignored
        bus.HSEL = 1'b1; bus.HADDR = BASE; bus.HTRANS = 2'b01; bus.HWRITE = 1'b1;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b10;
        @(negedge HCLK);
        chk("busy_state", {29'b0, dbg_state}, 32'd0);
        chk("busy_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        chk("nosel_state", {29'b0, dbg_state}, 32'd0);
        @(posedge HCLK); #1;

        // reset during RD_WAIT with two buffered writes
        tx_ready_dflt = 1'b0; bus.tx_ready = 1'b0;
        add(BASE, 1'b1, 2'b10, 3'b010, 3'b000, 32'h77, 1'b0, 0, '0);
        add(BASE, 1'b1, 2'b10, 3'b010, 3'b000, 32'h88, 1'b0, 0, '0);
        run_xfers();
        bus.HSEL = 1'b1; bus.HADDR = BASE; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        chk("rst_mid_rd_wait", {29'b0, dbg_state}, 32'd2);
        chk("rst_mid_tx_valid", {31'b0, bus.tx_valid}, 32'd1);
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        exp_q.delete();
        @(negedge HCLK);
        chk("rst2_state", {29'b0, dbg_state}, 32'd0);
        chk("rst2_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
        chk("rst2_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        chk("rst2_hresp", {31'b0, bus.HRESP}, 32'd0);
        @(posedge HCLK); #1;
`ifdef AHB_SLV_STATUS_EN
        add(BASE + 32'd4, 1'b0, 2'b10, 3'b010, 3'b000, '0, 1'b0, 1, 32'h00000000);
        run_xfers();
`endif
        cycles(2);
        chk("final_tx_q", exp_q.size(), 32'd0);
        chk("final_rd_q", rd_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
